// File: rtl/layer_mac_master.sv
// layer_mac_master: Avalon-MM master computing one fully-connected layer
// (N_OUT neurons x N_IN inputs) from SDRAM operands.
// Latency: per input two single-outstanding reads plus one ACC cycle; one
//   write plus one NEXT cycle per neuron.
// Backpressure: holds read_n/write_n/address/writedata while waitrequest=1
//   and waits indefinitely for readdatavalid.
// Ports: clk/reset; Avalon-MM master (waitrequest, readdatavalid, readdata,
//   chipselect, byteenable, read_n, write_n, address, writedata);
//   control (ready, mode, relu_en, done, busy, out_count).
module layer_mac_master #(
  parameter int          DATA_W    = 16,
  parameter int          ACC_W     = 32,
  parameter int          FRAC_BITS = 8,
  parameter int          N_IN      = 784,
  parameter int          N_OUT     = 200,
  parameter int unsigned IN_BASE   = 600000,
  parameter int unsigned W_BASE    = 800,
  parameter int unsigned OUT_BASE  = 400000,
  parameter int          ADDR_STEP = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                waitrequest,
  input  logic                readdatavalid,
  input  logic [DATA_W-1:0]   readdata,
  output logic                chipselect,
  output logic [DATA_W/8-1:0] byteenable,
  output logic                read_n,
  output logic                write_n,
  output logic [31:0]         address,
  output logic [DATA_W-1:0]   writedata,
  input  logic                ready,
  input  logic                mode,
  input  logic                relu_en,
  output logic                done,
  output logic                busy,
  output logic [15:0]         out_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_IN, S_WT_IN, S_RD_W, S_WT_W, S_ACC, S_WR, S_NEXT, S_DONE
  } state_t;

  localparam logic [31:0] IN_A   = 32'(IN_BASE);
  localparam logic [31:0] W_A    = 32'(W_BASE);
  localparam logic [31:0] OUT_A  = 32'(OUT_BASE);
  localparam logic [31:0] STEP   = 32'(ADDR_STEP);
  localparam logic [15:0] LAST_IN = 16'(N_IN - 1);
  localparam logic [15:0] NUM_OUT = 16'(N_OUT);

  // Signed DATA_W limits, sign-extended to the accumulator width.
  localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t                     state;
  logic [15:0]                in_idx;
  logic [15:0]                out_idx;
  logic [31:0]                in_adr;
  logic [31:0]                w_adr;
  logic [31:0]                out_adr;
  logic signed [DATA_W-1:0]   x;
  logic signed [DATA_W-1:0]   w;
  logic signed [ACC_W-1:0]    acc;
  logic                       mode_q;
  logic                       relu_q;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [2*DATA_W-1:0] shifted;
  logic signed [ACC_W-1:0]    term;
  logic signed [ACC_W-1:0]    acc_nxt;
  logic signed [ACC_W-1:0]    r_relu;
  logic [DATA_W-1:0]          r_sat;
  logic [15:0]                out_idx_nxt;

  assign chipselect = 1'b1;
  assign byteenable = '1;

  // Datapath: the term added in ACC and the saturated result of that sum,
  // so writedata can be registered on the ACC->WR transition.
  always_comb begin
    prod    = (2*DATA_W)'(x) * (2*DATA_W)'(w);
    shifted = prod >>> FRAC_BITS;
    term    = '0;
    if (mode_q)
      term = ACC_W'(shifted);
    else if (x != '0)
      term = ACC_W'(w);
    acc_nxt = acc + term;
    r_relu  = (relu_q && acc_nxt[ACC_W-1]) ? '0 : acc_nxt;
    if (r_relu > SMAX)
      r_sat = SMAX[DATA_W-1:0];
    else if (r_relu < SMIN)
      r_sat = SMIN[DATA_W-1:0];
    else
      r_sat = r_relu[DATA_W-1:0];
    out_idx_nxt = out_idx + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      read_n    <= 1'b1;
      write_n   <= 1'b1;
      address   <= '0;
      writedata <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      out_count <= '0;
      acc       <= '0;
      in_idx    <= '0;
      out_idx   <= '0;
      in_adr    <= IN_A;
      w_adr     <= W_A;
      out_adr   <= OUT_A;
      x         <= '0;
      w         <= '0;
      mode_q    <= 1'b0;
      relu_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          in_idx  <= '0;
          out_idx <= '0;
          in_adr  <= IN_A;
          w_adr   <= W_A;
          out_adr <= OUT_A;
          acc     <= '0;
          if (ready) begin
            mode_q    <= mode;
            relu_q    <= relu_en;
            out_count <= '0;
            busy      <= 1'b1;
            read_n    <= 1'b0;
            address   <= IN_A;
            state     <= S_RD_IN;
          end
        end
        S_RD_IN: if (!waitrequest) begin
          read_n <= 1'b1;
          state  <= S_WT_IN;
        end
        S_WT_IN: if (readdatavalid) begin
          x       <= readdata;
          in_adr  <= in_adr + STEP;
          read_n  <= 1'b0;
          address <= w_adr;
          state   <= S_RD_W;
        end
        S_RD_W: if (!waitrequest) begin
          read_n <= 1'b1;
          state  <= S_WT_W;
        end
        S_WT_W: if (readdatavalid) begin
          w     <= readdata;
          w_adr <= w_adr + STEP;
          state <= S_ACC;
        end
        S_ACC: begin
          acc    <= acc_nxt;
          in_idx <= in_idx + 16'd1;
          // in_idx still holds the index of the input just accumulated.
          if (in_idx == LAST_IN) begin
            writedata <= r_sat;
            write_n   <= 1'b0;
            address   <= out_adr;
            state     <= S_WR;
          end else begin
            read_n  <= 1'b0;
            address <= in_adr;
            state   <= S_RD_IN;
          end
        end
        S_WR: if (!waitrequest) begin
          write_n   <= 1'b1;
          out_adr   <= out_adr + STEP;
          out_count <= out_count + 16'd1;
          state     <= S_NEXT;
        end
        S_NEXT: begin
          acc     <= '0;
          in_idx  <= '0;
          in_adr  <= IN_A;
          out_idx <= out_idx_nxt;
          // w_adr is left alone: weight rows are stored back to back.
          if (out_idx_nxt == NUM_OUT) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            read_n  <= 1'b0;
            address <= IN_A;
            state   <= S_RD_IN;
          end
        end
        S_DONE: if (!ready) begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_mac_master.sv
// Bench for layer_mac_master with N_IN=4, N_OUT=2: a slave model serves
// reads from a sparse memory and a monitor checks every bus transaction
// against expectation queues filled when each run is launched.
module tb_layer_mac_master;

  localparam int          NI   = 4;
  localparam int          NO   = 2;
  localparam int unsigned INB  = 600000;
  localparam int unsigned WB   = 800;
  localparam int unsigned OUTB = 400000;

  typedef struct {
    logic [31:0] a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        waitrequest = 1'b0;
  logic        readdatavalid = 1'b0;
  logic [15:0] readdata = '0;
  logic        chipselect;
  logic [1:0]  byteenable;
  logic        read_n;
  logic        write_n;
  logic [31:0] address;
  logic [15:0] writedata;
  logic        ready = 1'b0;
  logic        mode = 1'b0;
  logic        relu_en = 1'b0;
  logic        done;
  logic        busy;
  logic [15:0] out_count;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [int unsigned];
  logic [31:0] rd_q [$];
  wr_t         wr_q [$];

  bit          rnd = 0;
  int          fixlat = 1;
  bit          seen_w = 0;
  bit          in_req = 0;
  int          stall = 0;
  bit          rd_pend = 0;
  int          rd_cnt = 0;
  logic [15:0] rd_dat = '0;

  layer_mac_master #(
    .DATA_W(16), .ACC_W(32), .FRAC_BITS(8), .N_IN(NI), .N_OUT(NO),
    .IN_BASE(INB), .W_BASE(WB), .OUT_BASE(OUTB), .ADDR_STEP(2)
  ) dut (
    .clk(clk), .reset(reset), .waitrequest(waitrequest),
    .readdatavalid(readdatavalid), .readdata(readdata),
    .chipselect(chipselect), .byteenable(byteenable),
    .read_n(read_n), .write_n(write_n), .address(address),
    .writedata(writedata), .ready(ready), .mode(mode), .relu_en(relu_en),
    .done(done), .busy(busy), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pk4(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // xs holds x[0..3]; w0/w1 hold weight rows 0 and 1 (element i at [16*i +: 16]).
  task automatic load(input logic [63:0] xs, input logic [63:0] w0, input logic [63:0] w1);
    for (int i = 0; i < NI; i++) begin
      mem[INB + 2*i]          = xs[16*i +: 16];
      mem[WB + 2*i]           = w0[16*i +: 16];
      mem[WB + 2*(NI + i)]    = w1[16*i +: 16];
    end
  endtask

  task automatic expect_run(input logic [15:0] e0, input logic [15:0] e1);
    wr_t t;
    for (int o = 0; o < NO; o++)
      for (int i = 0; i < NI; i++) begin
        rd_q.push_back(INB + 2*i);
        rd_q.push_back(WB + 2*(o*NI + i));
      end
    t.a = OUTB;     t.d = e0; wr_q.push_back(t);
    t.a = OUTB + 2; t.d = e1; wr_q.push_back(t);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_read_n"},    {31'd0, read_n},  32'd1);
    chk({tag, "_write_n"},   {31'd0, write_n}, 32'd1);
    chk({tag, "_address"},   address,          32'd0);
    chk({tag, "_writedata"}, {16'd0, writedata}, 32'd0);
    chk({tag, "_done"},      {31'd0, done},    32'd0);
    chk({tag, "_busy"},      {31'd0, busy},    32'd0);
    chk({tag, "_out_count"}, {16'd0, out_count}, 32'd0);
  endtask

  // flip: after start, drop ready and invert mode/relu_en; none may matter.
  task automatic run_job(input string nm, input logic m, input logic r,
                         input logic [15:0] e0, input logic [15:0] e1, input bit flip);
    expect_run(e0, e1);
    mode = m; relu_en = r; ready = 1'b1;
    @(posedge clk); #2;
    chk({nm, "_busy_start"}, {31'd0, busy}, 32'd1);
    if (flip) begin
      mode = ~m; relu_en = ~r; ready = 1'b0;
    end
    for (int c = 0; c < 3000; c++) begin
      if (done) break;
      @(posedge clk); #2;
    end
    chk({nm, "_done"},       {31'd0, done},      32'd1);
    chk({nm, "_out_count"},  {16'd0, out_count}, 32'd2);
    chk({nm, "_busy_done"},  {31'd0, busy},      32'd0);
    chk({nm, "_reads_left"}, rd_q.size(),        32'd0);
    chk({nm, "_writes_left"}, wr_q.size(),       32'd0);
    ready = 1'b0;
    @(posedge clk); #2;
    chk({nm, "_done_fall"},  {31'd0, done},      32'd0);
  endtask

  // Slave model and monitor.
  always @(posedge clk) begin
    bit pend0;
    wr_t t;
    #1;
    pend0 = rd_pend;
    readdatavalid = 1'b0;
    if (rd_pend) begin
      if (rd_cnt <= 1) begin
        readdatavalid = 1'b1;
        readdata      = rd_dat;
        rd_pend       = 0;
      end else
        rd_cnt--;
    end
    waitrequest = 1'b0;
    if (reset) begin
      in_req = 0;
    end else if (!read_n || !write_n) begin
      if (!in_req) begin
        in_req = 1;
        stall  = rnd ? int'($urandom_range(0, 3)) : 0;
      end
      chk("rd_wr_exclusive", {31'd0, read_n | write_n}, 32'd1);
      if (!read_n)
        chk("rd_while_pending", {31'd0, pend0}, 32'd0);
      if (!write_n) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", address, writedata);
        end else begin
          if (address !== wr_q[0].a || writedata !== wr_q[0].d) begin
            errors++;
            $display("FAIL write: got addr %h data %h expected addr %h data %h",
                     address, writedata, wr_q[0].a, wr_q[0].d);
          end
        end
      end
      if (stall > 0) begin
        waitrequest = 1'b1;
        stall--;
      end else begin
        in_req = 0;
        if (!read_n) begin
          checks++;
          if (rd_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_read: got addr %h expected no read", address);
          end else begin
            if (address !== rd_q[0]) begin
              errors++;
              $display("FAIL read_addr: got %h expected %h", address, rd_q[0]);
            end
            void'(rd_q.pop_front());
          end
          if (address == WB) seen_w = 1;
          rd_dat  = mem.exists(address) ? mem[address] : 16'hDEAD;
          rd_pend = 1;
          rd_cnt  = rnd ? int'($urandom_range(1, 5)) : fixlat;
        end else if (wr_q.size() != 0) begin
          t = wr_q.pop_front();
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk_reset_vals("reset");
    chk("chipselect", {31'd0, chipselect}, 32'd1);
    chk("byteenable", {30'd0, byteenable}, 32'd3);
    reset = 1'b0;
    @(posedge clk); #2;

    // x = {0,1,5,0}; rows {1,2,3,4} and {-1,-2,-3,-4}
    load(pk4(16'd0, 16'd1, 16'd5, 16'd0),
         pk4(16'd1, 16'd2, 16'd3, 16'd4),
         pk4(16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC));
    run_job("m0", 1'b0, 1'b0, 16'h0005, 16'hFFFB, 0);
    run_job("m0_relu", 1'b0, 1'b1, 16'h0005, 16'h0000, 0);

    // x = all 1.0; row0 0.5+0.5+1-1 = 1.0; row1 4*10000 saturates high
    load(pk4(16'h0100, 16'h0100, 16'h0100, 16'h0100),
         pk4(16'h0080, 16'h0080, 16'h0100, 16'hFF00),
         pk4(16'd10000, 16'd10000, 16'd10000, 16'd10000));
    run_job("m1_pos", 1'b1, 1'b0, 16'h0100, 16'h7FFF, 0);

    // row0 4*(-10000) saturates low; row1 -1-1 = -2.0
    load(pk4(16'h0100, 16'h0100, 16'h0100, 16'h0100),
         pk4(16'hD8F0, 16'hD8F0, 16'hD8F0, 16'hD8F0),
         pk4(16'hFF00, 16'hFF00, 16'h0000, 16'h0000));
    run_job("m1_neg", 1'b1, 1'b0, 16'h8000, 16'hFE00, 0);

    // Random stalls/latency, with ready/mode/relu_en changed mid-run.
    load(pk4(16'd0, 16'd1, 16'd5, 16'd0),
         pk4(16'd1, 16'd2, 16'd3, 16'd4),
         pk4(16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC));
    rnd = 1;
    run_job("rand", 1'b0, 1'b0, 16'h0005, 16'hFFFB, 1);
    rnd = 0;

    // Reset while waiting for the first weight, response lands just after.
    fixlat = 2;
    seen_w = 0;
    expect_run(16'h0005, 16'hFFFB);
    mode = 1'b0; relu_en = 1'b0; ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #2;
      if (seen_w) break;
    end
    chk("abort_reached_rd_w", {31'd0, seen_w}, 32'd1);
    @(posedge clk); #2;
    reset = 1'b1; ready = 1'b0;
    @(posedge clk); #2;
    chk_reset_vals("abort");
    reset = 1'b0;
    rd_q.delete();
    wr_q.delete();
    repeat (6) @(posedge clk);
    #2;
    chk("abort_idle_busy",   {31'd0, busy},    32'd0);
    chk("abort_idle_read_n", {31'd0, read_n},  32'd1);
    chk("abort_idle_write_n", {31'd0, write_n}, 32'd1);
    fixlat = 1;
    rnd = 1;
    run_job("after_abort", 1'b0, 1'b0, 16'h0005, 16'hFFFB, 0);
    rnd = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
